alu_control_pipe: RTL and testbench
===================================

Name: alu_control_pipe

Overview:
Registered, handshaked successor to the combinational ALU control decoder, for the pipelined RV32 core. It decodes {funct7, ALU_Op, funct3} into a widened ALU operation code covering the full RV32I ALU set plus the optional RV32M ops. The result is held in a one-entry output stage with valid/ready handshakes. For multiply/divide ops it stalls upstream for a configurable number of cycles, so the execute stage sees a multi-cycle unit as a fixed-latency operation.

Parameters:
OP_W, 5, ALU operation code width; must be >=5; codes zero-extended above bit 4.
MUL_LAT, 2, cycles from accept to valid_o for MUL/MULH/MULHSU/MULHU; must be >=1.
DIV_LAT, 32, cycles from accept to valid_o for DIV/DIVU/REM/REMU; must be >=1.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high reset
valid_i  input  1  upstream decode fields valid
ready_o  output  1  block accepts fields this cycle
funct7_i  input  7  instruction funct7 (full field)
alu_op_i  input  3  ALU_Op from main control
funct3_i  input  3  instruction funct3
flush_i  input  1  discard held/in-flight op (branch redirect)
valid_o  output  1  alu_operation_o valid
ready_i  input  1  execute stage consumes output
alu_operation_o  output  OP_W  ALU operation code
is_mdu_o  output  1  held op is an M-extension op
illegal_o  output  1  held op was an undefined encoding
stall_o  output  1  high while in BUSY

Behaviour:
- Op codes: ADD 00000, SUB 00001, AND 00010, OR 00011, PASSB 00100, XOR 00101, SLL 00110, SRL 00111, SRA 01000, SLT 01001, SLTU 01010. M-extension ops: {2'b10, funct3}, i.e. MUL 10000 through REMU 10111.
- alu_op 000 (R-type):
  - funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000: funct3 000 SUB, 101 SRA; other funct3 illegal.
  - funct7 0000001: M-extension op.
  - Any other funct7: illegal.
- alu_op 001 (I-type ALU):
  - funct3 as for R-type, but funct3 000 is always ADD (funct7 ignored).
  - funct3 001 requires funct7 0000000.
  - funct3 101: funct7 0000000 gives SRL, 0100000 gives SRA; any other funct7 is illegal.
- alu_op 010 (LUI): PASSB.
- alu_op 011 (branch): funct3 00x SUB, 10x SLT, 11x SLTU, 01x illegal.
- alu_op 100/101/110 (load-store, JALR, AUIPC): ADD.
- alu_op 111: illegal.
- Illegal encodings: code ADD, illegal_o=1, is_mdu_o=0, and the op follows the non-MDU path.
- FSM states EMPTY, BUSY, FULL. Reset enters EMPTY with valid_o=0, alu_operation_o=0, is_mdu_o=0, illegal_o=0, stall_o=0, counter=0.
- EMPTY:
  - ready_o=1.
  - On valid_i: register the decode. A non-MDU op goes to FULL. An MDU op loads cnt=LAT-1 and goes to BUSY, or straight to FULL if LAT==1.
- BUSY:
  - ready_o=0, valid_o=0, stall_o=1; outputs already hold the op.
  - cnt decrements each cycle; at the edge where cnt==1, go to FULL.
  - Net effect: an op accepted at edge T shows valid_o from edge T+LAT. Non-MDU ops have latency 1.
- FULL:
  - valid_o=1, ready_o=ready_i (combinational, allows back-to-back ops).
  - ready_i & valid_i: accept the new op; next state as from EMPTY.
  - ready_i & !valid_i: go to EMPTY.
  - !ready_i: all outputs held stable.
- LAT is DIV_LAT when funct3[2]=1, else MUL_LAT. The counter is $clog2(max(MUL_LAT,DIV_LAT)+1) bits wide.
- flush_i, priority below reset and above everything else:
  - ready_o=0 in the same cycle.
  - Next state EMPTY; counter cleared; valid_o=0.
  - Output data registers keep their value.
- Reset mid-BUSY: EMPTY next cycle, no output produced.

Optional Feature:
RV32M_EN.
- Defined: M-extension decode and the BUSY path as above.
- Undefined: R-type funct7 0000001 is illegal; the BUSY state, counter, MUL_LAT and DIV_LAT logic are compiled out; is_mdu_o and stall_o are tied to 0.

Decomposition:
- Shared package/header (alu_ctrl_pkg): ALU_Op encodings (R, I, LUI, BR, LS, JALR, AUIPC), the 5-bit op code constants, funct7 constants (BASE 0000000, ALT 0100000, MULDIV 0000001), and FSM state encodings.
- Sub-module alu_ctrl_decode: purely combinational decode to {code, is_mdu, illegal}. It is reusable by the single-cycle core.
- The top level holds the FSM, latency counter and output registers.

Test Plan:
- Reset then R-type ADD (f7=0, op=000, f3=000) with ready_i=1: valid_o at edge+1, code 00000, ready_o stays 1; same for SUB (f7=0100000) giving 00001 and LUI (op=010) giving 00100.
- Back-to-back I-type SRAI, then XORI, then branch BLTU, with ready_i=1: codes 01000, 00101, 01010 on consecutive cycles, no bubbles.
- Backpressure: ready_i=0 for 3 cycles after valid_o: output and code held stable, ready_o=0, next op accepted on the cycle ready_i rises.
- With RV32M_EN, DIV (f7=0000001, f3=100), DIV_LAT=32:
  - stall_o high for 31 cycles; valid_o at edge+32 with code 10100, is_mdu_o=1.
  - MUL with MUL_LAT=2: valid_o at edge+2 with code 10000.
- flush_i asserted in BUSY cycle 5 of a DIV: EMPTY next cycle, valid_o never rises, next ADD accepted normally. Reset asserted mid-BUSY gives the same result.
- Illegal encodings: op=111, and R-type f7=0100000 f3=001: illegal_o=1, code 00000, latency 1. Without RV32M_EN, f7=0000001 gives illegal_o=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control decoder and its pipelined wrapper.
//   - ALU_Op encodings produced by the main control unit
//   - 5-bit ALU operation codes (RV32I set plus RV32M codes {2'b10, funct3})
//   - funct7 values that select base, alternate and mul/div variants
//   - FSM state encoding for the output stage of alu_control_pipe
package alu_ctrl_pkg;

  // ALU_Op from main control (3'b111 is undefined)
  localparam logic [2:0] ALUOP_R     = 3'b000;
  localparam logic [2:0] ALUOP_I     = 3'b001;
  localparam logic [2:0] ALUOP_LUI   = 3'b010;
  localparam logic [2:0] ALUOP_BR    = 3'b011;
  localparam logic [2:0] ALUOP_LS    = 3'b100;
  localparam logic [2:0] ALUOP_JALR  = 3'b101;
  localparam logic [2:0] ALUOP_AUIPC = 3'b110;

  // ALU operation codes
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_PASSB = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;

  // funct7 selectors
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Output-stage FSM states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // Base-variant op for a funct3 (shared by R-type and I-type decode)
  function automatic logic [4:0] base_code(input logic [2:0] f3);
    logic [4:0] c;
    case (f3)
      3'b000:  c = OP_ADD;
      3'b001:  c = OP_SLL;
      3'b010:  c = OP_SLT;
      3'b011:  c = OP_SLTU;
      3'b100:  c = OP_XOR;
      3'b101:  c = OP_SRL;
      3'b110:  c = OP_OR;
      3'b111:  c = OP_AND;
      default: c = OP_ADD;
    endcase
    return c;
  endfunction

  // M-extension op code: MUL..REMU map directly onto funct3
  function automatic logic [4:0] mdu_code(input logic [2:0] f3);
    return {2'b10, f3};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALU control decode: {funct7, alu_op, funct3} ->
// {code, is_mdu, illegal}. Reusable by the single-cycle core.
// Optional feature macro: RV32M_EN (adds M-extension decode and is_mdu_o).
// Ports:
//   funct7_i  [6:0]  instruction funct7
//   alu_op_i  [2:0]  ALU_Op from main control
//   funct3_i  [2:0]  instruction funct3
//   code_o    [4:0]  ALU operation code (ADD for illegal encodings)
//   is_mdu_o         M-extension op (only with RV32M_EN)
//   illegal_o        undefined encoding
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] funct7_i,
  input  logic [2:0] alu_op_i,
  input  logic [2:0] funct3_i,
  output logic [4:0] code_o,
`ifdef RV32M_EN
  output logic       is_mdu_o,
`endif
  output logic       illegal_o
);

  logic mdu_s;

  // Decode table; illegal encodings leave code at ADD with mdu cleared
  always_comb begin
    code_o    = OP_ADD;
    mdu_s     = 1'b0;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_R: begin
        case (funct7_i)
          F7_BASE: code_o = base_code(funct3_i);
          F7_ALT: begin
            if (funct3_i == 3'b000) begin
              code_o = OP_SUB;
            end else if (funct3_i == 3'b101) begin
              code_o = OP_SRA;
            end else begin
              illegal_o = 1'b1;
            end
          end
`ifdef RV32M_EN
          F7_MULDIV: begin
            code_o = mdu_code(funct3_i);
            mdu_s  = 1'b1;
          end
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      ALUOP_I: begin
        // funct7 carries immediate bits here; it only qualifies the shifts
        if (funct3_i == 3'b001) begin
          if (funct7_i == F7_BASE) begin
            code_o = OP_SLL;
          end else begin
            illegal_o = 1'b1;
          end
        end else if (funct3_i == 3'b101) begin
          if (funct7_i == F7_BASE) begin
            code_o = OP_SRL;
          end else if (funct7_i == F7_ALT) begin
            code_o = OP_SRA;
          end else begin
            illegal_o = 1'b1;
          end
        end else begin
          code_o = base_code(funct3_i);
        end
      end
      ALUOP_LUI: code_o = OP_PASSB;
      ALUOP_BR: begin
        case (funct3_i[2:1])
          2'b00:   code_o = OP_SUB;
          2'b10:   code_o = OP_SLT;
          2'b11:   code_o = OP_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      ALUOP_LS, ALUOP_JALR, ALUOP_AUIPC: code_o = OP_ADD;
      default: illegal_o = 1'b1;
    endcase
  end

`ifdef RV32M_EN
  assign is_mdu_o = mdu_s;
`endif

endmodule

// File: rtl/alu_control_pipe.sv
// Registered, handshaked ALU control decode for the pipelined RV32 core.
// A one-entry output stage (EMPTY/BUSY/FULL) holds the decoded op; M-extension
// ops park in BUSY for LAT-1 cycles so execute sees a fixed-latency unit.
// Optional feature macro: RV32M_EN (M decode, BUSY state and latency counter).
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   valid_i / ready_o       upstream handshake for funct7_i, alu_op_i, funct3_i
//   flush_i                 drop held/in-flight op, data registers keep value
//   valid_o / ready_i       downstream handshake
//   alu_operation_o [OP_W]  op code, zero-extended above bit 4
//   is_mdu_o, illegal_o     attributes of the held op
//   stall_o                 high while waiting out a mul/div latency
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OP_W-1:0] alu_operation_o,
  output logic            is_mdu_o,
  output logic            illegal_o,
  output logic            stall_o
);

  if (OP_W < 5 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_cfg
    $error("alu_control_pipe: OP_W must be >=5, MUL_LAT and DIV_LAT >=1");
  end

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              ill_q, ill_d;
  logic [4:0]        dec_code_s;
  logic              dec_illegal_s;
  logic              ready_s;
  logic              accept_s;

`ifdef RV32M_EN
  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic             dec_is_mdu_s;
  logic             mdu_q, mdu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_m1_s;

  // funct3[2] separates DIV/REM from MUL variants
  assign lat_m1_s = funct3_i[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
`endif

  alu_ctrl_decode u_decode (
    .funct7_i  (funct7_i),
    .alu_op_i  (alu_op_i),
    .funct3_i  (funct3_i),
    .code_o    (dec_code_s),
`ifdef RV32M_EN
    .is_mdu_o  (dec_is_mdu_s),
`endif
    .illegal_o (dec_illegal_s)
  );

  // Upstream ready: flush blocks intake; FULL passes ready_i through for back-to-back ops
  always_comb begin
    ready_s = 1'b0;
    if (flush_i) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: ready_s = 1'b1;
        ST_FULL:  ready_s = ready_i;
        default:  ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = valid_i & ready_s;
  assign ready_o  = ready_s;

  // Next-state and next-data logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q;
`ifdef RV32M_EN
    mdu_d   = mdu_q;
    cnt_d   = cnt_q;
`endif
    if (flush_i) begin
      state_d = ST_EMPTY;
`ifdef RV32M_EN
      cnt_d   = {CNT_W{1'b0}};
`endif
    end else if (accept_s) begin
      op_d  = OP_W'(dec_code_s);
      ill_d = dec_illegal_s;
`ifdef RV32M_EN
      mdu_d = dec_is_mdu_s;
      if (dec_is_mdu_s && (lat_m1_s != {CNT_W{1'b0}})) begin
        state_d = ST_BUSY;
        cnt_d   = lat_m1_s;
      end else begin
        state_d = ST_FULL;
      end
`else
      state_d = ST_FULL;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_FULL: begin
          if (ready_i) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
`ifdef RV32M_EN
        ST_BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_BUSY;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and output-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      op_q    <= {OP_W{1'b0}};
      ill_q   <= 1'b0;
`ifdef RV32M_EN
      mdu_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
`ifdef RV32M_EN
      mdu_q   <= mdu_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    valid_o = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      ST_FULL: valid_o = 1'b1;
`ifdef RV32M_EN
      ST_BUSY: stall_o = 1'b1;
`endif
      default: begin
        valid_o = 1'b0;
        stall_o = 1'b0;
      end
    endcase
  end

  assign alu_operation_o = op_q;
  assign illegal_o       = ill_q;
`ifdef RV32M_EN
  assign is_mdu_o        = mdu_q;
`else
  assign is_mdu_o        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level
// reference model (decode tables plus a countdown of remaining latency).
module tb_alu_control_pipe;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic       ready_o;
  logic [6:0] funct7_i;
  logic [2:0] alu_op_i;
  logic [2:0] funct3_i;
  logic       flush_i;
  logic       valid_o;
  logic       ready_i;
  logic [4:0] alu_operation_o;
  logic       is_mdu_o;
  logic       illegal_o;
  logic       stall_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // R-type base table indexed by funct3: ADD SLL SLT SLTU XOR SRL OR AND
  int base_tbl [8] = '{0, 6, 9, 10, 5, 7, 3, 2};

  // Reference model of the held op
  bit m_valid = 1'b0;
  int m_wait  = 0;
  int m_code  = 0;
  bit m_mdu   = 1'b0;
  bit m_ill   = 1'b0;

`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  alu_control_pipe #(.OP_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .funct7_i        (funct7_i),
    .alu_op_i        (alu_op_i),
    .funct3_i        (funct3_i),
    .flush_i         (flush_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .alu_operation_o (alu_operation_o),
    .is_mdu_o        (is_mdu_o),
    .illegal_o       (illegal_o),
    .stall_o         (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] f7, input logic [2:0] op,
                                     input logic [2:0] f3, output int code,
                                     output bit mdu, output bit ill);
    code = 0;
    mdu  = 1'b0;
    ill  = 1'b0;
    case (int'(op))
      0: begin
        if (f7 == 7'd0) code = base_tbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) code = 8;
        else if (f7 == 7'd1 && M_EN) begin code = 16 + int'(f3); mdu = 1'b1; end
        else ill = 1'b1;
      end
      1: begin
        if (f3 == 3'd1 && f7 != 7'd0) ill = 1'b1;
        else if (f3 == 3'd5) begin
          if (f7 == 7'd0) code = 7;
          else if (f7 == 7'h20) code = 8;
          else ill = 1'b1;
        end else code = base_tbl[f3];
      end
      2: code = 4;
      3: begin
        if (f3 <= 3'd1) code = 1;
        else if (f3 <= 3'd3) ill = 1'b1;
        else if (f3 <= 3'd5) code = 9;
        else code = 10;
      end
      7: ill = 1'b1;
      default: code = 0;
    endcase
    if (ill) code = 0;
  endfunction

  // One clock cycle: drive, check against model, advance model at the edge
  task automatic step(input bit v, input logic [6:0] f7, input logic [2:0] op,
                      input logic [2:0] f3, input bit rdy, input bit fl, input bit rst);
    bit exp_ready;
    bit acc;
    int code;
    bit mdu;
    bit ill;
    @(negedge clk);
    valid_i  = v;
    funct7_i = f7;
    alu_op_i = op;
    funct3_i = f3;
    ready_i  = rdy;
    flush_i  = fl;
    reset    = rst;
    #1;
    exp_ready = !fl && (m_wait == 0) && (!m_valid || rdy);
    check_eq("ready_o", 32'(ready_o), 32'(exp_ready));
    check_eq("valid_o", 32'(valid_o), 32'(m_valid));
    check_eq("stall_o", 32'(stall_o), 32'(m_wait != 0));
    check_eq("alu_operation_o", 32'(alu_operation_o), 32'(m_code));
    check_eq("is_mdu_o", 32'(is_mdu_o), 32'(m_mdu));
    check_eq("illegal_o", 32'(illegal_o), 32'(m_ill));
    acc = v && exp_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 1'b0; m_wait = 0; m_code = 0; m_mdu = 1'b0; m_ill = 1'b0;
    end else if (fl) begin
      m_valid = 1'b0; m_wait = 0;
    end else if (acc) begin
      ref_decode(f7, op, f3, code, mdu, ill);
      m_code = code; m_mdu = mdu; m_ill = ill;
      m_wait  = mdu ? ((f3[2] ? DIV_LAT : MUL_LAT) - 1) : 0;
      m_valid = (m_wait == 0);
    end else if (m_wait != 0) begin
      m_wait--;
      m_valid = (m_wait == 0);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 3'd0, 3'd0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; funct7_i = 7'd0; alu_op_i = 3'd0;
    funct3_i = 3'd0; flush_i = 1'b0; ready_i = 1'b1;
    step(1'b0, 7'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 7'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    // ADD, SUB, LUI back-to-back
    step(1'b1, 7'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h20, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h00, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0);
    // SRAI, XORI, BLTU
    step(1'b1, 7'h20, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h55, 3'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h00, 3'd3, 3'd6, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    // Backpressure: hold for 3 cycles, then next op enters as ready_i rises
    step(1'b1, 7'h00, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h20, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h20, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h20, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h20, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    // Illegal encodings and the mul/div funct7
    step(1'b1, 7'h00, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h20, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    // DIV full latency, then MUL
    step(1'b1, 7'h01, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    idle(DIV_LAT + 2, 1'b1);
    step(1'b1, 7'h01, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    // Flush in BUSY cycle 5 of a DIV, then ADD
    step(1'b1, 7'h01, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b1, 7'h00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    idle(DIV_LAT, 1'b1);
    step(1'b1, 7'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    // Reset mid-BUSY, then ADD
    step(1'b1, 7'h01, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b0, 7'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    idle(DIV_LAT, 1'b1);
    step(1'b1, 7'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] f7;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, f7, 3'($urandom), 3'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) < 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
